// File: rtl/cmd_pkg.sv
// Shared definitions for the command transmit encoder.
// Holds the ten-entry ASCII command table, the named command indices,
// the encoder state encoding and a table lookup helper.
package cmd_pkg;

  localparam int NUM_CMDS = 10;

  // Named command indices; bit k of a request vector selects command k.
  localparam logic [3:0] CMD_G1 = 4'd0;
  localparam logic [3:0] CMD_G0 = 4'd1;
  localparam logic [3:0] CMD_H1 = 4'd2;
  localparam logic [3:0] CMD_H0 = 4'd3;
  localparam logic [3:0] CMD_I1 = 4'd4;
  localparam logic [3:0] CMD_I0 = 4'd5;
  localparam logic [3:0] CMD_J1 = 4'd6;
  localparam logic [3:0] CMD_J0 = 4'd7;
  localparam logic [3:0] CMD_O1 = 4'd8;
  localparam logic [3:0] CMD_O0 = 4'd9;

  // Two ASCII characters per command, first character in the upper byte.
  // Element [0] is the last entry of the concatenation.
  localparam logic [NUM_CMDS-1:0][15:0] CMD_TABLE = {
    16'h4F30,  // 9 "O0"
    16'h4F31,  // 8 "O1"
    16'h4A30,  // 7 "J0"
    16'h4A31,  // 6 "J1"
    16'h4930,  // 5 "I0"
    16'h4931,  // 4 "I1"
    16'h4830,  // 3 "H0"
    16'h4831,  // 2 "H1"
    16'h4730,  // 1 "G0"
    16'h4731   // 0 "G1"
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_HI = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  // Table lookup; an index outside the table yields two NUL bytes.
  function automatic logic [15:0] cmd_code(input logic [3:0] idx);
    if (idx <= CMD_O0) begin
      return CMD_TABLE[idx];
    end else begin
      return 16'h0000;
    end
  endfunction

endpackage

// File: rtl/cmd_arb.sv
// Lowest-index priority encoder over the pending command vector.
// Ports:
//   pending  in   request vector, bit k = command k waiting
//   idx      out  lowest set index (CMD_G1 when nothing is set)
//   valid    out  at least one bit of pending is set
module cmd_arb
  import cmd_pkg::*;
(
  input  logic [NUM_CMDS-1:0] pending,
  output logic [3:0]          idx,
  output logic                valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = CMD_G1;
    for (int k = NUM_CMDS - 1; k >= 0; k--) begin
      idx = pending[k] ? 4'(k) : idx;
    end
    valid = |pending;
  end

endmodule

// File: rtl/cmd_tx_encoder.sv
// Turns one-cycle event requests into two-byte ASCII commands for a UART.
// Requests are queued in a pending bit vector, served lowest index first,
// each byte handed over with a tx_en pulse and acknowledged by tx_done,
// and every finished command is followed by an idle gap.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   ev_req    in   one-cycle request pulses, bit k = command k
//   tx_done   in   UART finished the current byte
//   tx_data   out  byte for the UART, held while tx_en is low
//   tx_en     out  one-cycle transmit request
//   busy      out  encoder not idle
//   cmd_sent  out  one-cycle pulse after the second byte completes
//   pending   out  requested commands not yet started
module cmd_tx_encoder
  import cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int CMD_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CMDS-1:0] ev_req,
  input  logic                tx_done,
  output logic [7:0]          tx_data,
  output logic                tx_en,
  output logic                busy,
  output logic                cmd_sent,
  output logic [NUM_CMDS-1:0] pending
);

  // A zero gap still spends one cycle in GAP, so the counter keeps one bit.
  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_CMDS-1:0] ONE_HOT0 = NUM_CMDS'(1);

  state_e              state_q, state_d;
  logic [3:0]          cmd_idx_q, cmd_idx_d;
  logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_CMDS-1:0] pend_q, pend_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q, busy_d;
  logic                cmd_sent_q, cmd_sent_d;

  logic [3:0]          arb_idx_s;
  logic                arb_valid_s;
  logic [NUM_CMDS-1:0] clr_mask_s;
  logic [CMD_W-1:0]    cmd_word_s;

  cmd_arb u_arb (
    .pending (pend_q),
    .idx     (arb_idx_s),
    .valid   (arb_valid_s)
  );

  assign cmd_word_s = CMD_W'(cmd_code(cmd_idx_q));

  // Next-state, pending update and registered output values.
  always_comb begin
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = 1'b0;
    cmd_sent_d = 1'b0;
    clr_mask_s = {NUM_CMDS{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          cmd_idx_d  = arb_idx_s;
          clr_mask_s = ONE_HOT0 << arb_idx_s;
          state_d    = ST_SEND_HI;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SEND_HI: begin
        tx_en_d   = 1'b1;
        tx_data_d = cmd_word_s[CMD_W-1 -: 8];
        state_d   = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_done) begin
          state_d = ST_SEND_LO;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_SEND_LO: begin
        tx_en_d   = 1'b1;
        tx_data_d = cmd_word_s[7:0];
        state_d   = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (tx_done) begin
          cmd_sent_d = 1'b1;
          gap_cnt_d  = {CNT_W{1'b0}};
          state_d    = ST_GAP;
        end else begin
          state_d    = ST_WAIT_LO;
        end
      end
      ST_GAP: begin
        // The counter stops at GAP_LAST, so it can never wrap.
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
          state_d   = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request for the bit being cleared this cycle survives.
    pend_d = (pend_q & ~clr_mask_s) | ev_req;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_idx_q  <= CMD_G1;
      gap_cnt_q  <= {CNT_W{1'b0}};
      pend_q     <= {NUM_CMDS{1'b0}};
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pend_q     <= pend_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_cmd_tx_encoder.sv
// Randomized bench for cmd_tx_encoder. Two instances (gap 16 and gap 0)
// share requests and reset. A schedule model predicts, per clock cycle,
// when each byte is offered, which byte it is, when cmd_sent pulses,
// the busy window and the pending set; it also plays the UART, so every
// tx_done it drives comes from its own predicted timeline.
module tb_cmd_tx_encoder;

  localparam int NC   = 3000;
  localparam int MAXC = NC + 80;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] ev_req;
  logic       tx_done  [2];
  logic [7:0] tx_data  [2];
  logic       tx_en    [2];
  logic       busy     [2];
  logic       cmd_sent [2];
  logic [9:0] pending  [2];

  always #5 clk = ~clk;

  cmd_tx_encoder #(.GAP_CYCLES(16), .CMD_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .ev_req(ev_req), .tx_done(tx_done[0]),
    .tx_data(tx_data[0]), .tx_en(tx_en[0]), .busy(busy[0]),
    .cmd_sent(cmd_sent[0]), .pending(pending[0])
  );

  cmd_tx_encoder #(.GAP_CYCLES(0), .CMD_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .ev_req(ev_req), .tx_done(tx_done[1]),
    .tx_data(tx_data[1]), .tx_en(tx_en[1]), .busy(busy[1]),
    .cmd_sent(cmd_sent[1]), .pending(pending[1])
  );

  // Predicted timeline per instance, indexed by cycle number.
  bit         m_en   [2][MAXC];
  logic [7:0] m_byte [2][MAXC];
  bit         m_sent [2][MAXC];
  bit [1:0]   m_wait [2][MAXC];   // 1 = waiting on first byte, 2 = on second
  bit         m_done [2][MAXC];
  logic [9:0] m_pend [2];
  logic [7:0] m_last [2];
  int         m_free [2];
  int         m_blo  [2];
  int         m_bhi  [2];
  int         gap_of [2];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    string      tbl;
    logic [9:0] ev;
    logic [9:0] clr [2];
    int         sel [2];
    bit         r;
    int         rst_left, lo_rst_cyc, e1, e2, d1, d2, dly;
    bit         lo_rst_done, resel_done;
    logic [7:0] exp_d;

    tbl         = "G1G0H1H0I1I0J1J0O1O0";
    gap_of[0]   = 16;
    gap_of[1]   = 0;
    rst_left    = 0;
    lo_rst_cyc  = -100;
    lo_rst_done = 1'b0;
    resel_done  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 10'd0;
      m_last[i] = 8'h00;
      m_free[i] = 0;
      m_blo[i]  = 1;
      m_bhi[i]  = 0;
      tx_done[i] = 1'b0;
    end
    rst    = 1'b1;
    ev_req = 10'd0;

    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;

      // Reset for this cycle: power-up, one in the middle of a second
      // byte, then occasional random ones.
      r = 1'b0;
      if (c < 3) begin
        r = 1'b1;
      end else if (rst_left > 0) begin
        r = 1'b1;
        rst_left--;
      end else if (!lo_rst_done && c >= 400 && m_wait[0][c] == 2'd2) begin
        r = 1'b1;
        rst_left = 1;
        lo_rst_done = 1'b1;
        lo_rst_cyc = c;
      end else if (c >= 600 && $urandom_range(0, 499) == 0) begin
        r = 1'b1;
      end

      // Idle encoder with something pending starts the lowest index now.
      for (int i = 0; i < 2; i++) begin
        clr[i] = 10'd0;
        sel[i] = -1;
        if (!r && c >= m_free[i] && m_pend[i] != 10'd0) begin
          for (int k = 9; k >= 0; k--) begin
            if (m_pend[i][k]) sel[i] = k;
          end
          clr[i][sel[i]] = 1'b1;
          dly = (c < 60) ? 4 : $urandom_range(0, 6);
          e1 = c + 2;
          m_en[i][e1] = 1'b1;
          m_byte[i][e1] = tbl[2*sel[i]];
          d1 = e1 + dly;
          for (int x = e1; x <= d1; x++) m_wait[i][x] = 2'd1;
          m_done[i][d1] = 1'b1;
          dly = (c < 60) ? 4 : $urandom_range(0, 6);
          e2 = d1 + 2;
          m_en[i][e2] = 1'b1;
          m_byte[i][e2] = tbl[2*sel[i]+1];
          d2 = e2 + dly;
          for (int x = e2; x <= d2; x++) m_wait[i][x] = 2'd2;
          m_done[i][d2] = 1'b1;
          m_sent[i][d2+1] = 1'b1;
          m_blo[i]  = c + 1;
          m_free[i] = d2 + 1 + ((gap_of[i] == 0) ? 1 : gap_of[i]);
          m_bhi[i]  = m_free[i] - 1;
        end
      end

      // Requests: a few fixed scenarios first, random traffic later.
      ev = 10'd0;
      case (c)
        3:          ev = 10'b0000000001;
        80:         ev = 10'b1000000001;
        84, 86, 88: ev = 10'b0000000100;
        130:        ev = 10'b0011000000;
        200:        ev = 10'b0000010000;
        default: begin
          if (c >= 250) begin
            if ($urandom_range(0, 9) == 0) begin
              ev = 10'd1 << $urandom_range(0, 9);
            end else if ($urandom_range(0, 29) == 0) begin
              ev = 10'($urandom_range(0, 1023));
            end
          end
        end
      endcase
      if (lo_rst_done && c == lo_rst_cyc + 10) ev = 10'b0000010000;
      if (sel[0] == 4 && !resel_done) begin
        ev[4] = 1'b1;
        resel_done = 1'b1;
      end
      if (sel[0] >= 0 && $urandom_range(0, 3) == 0) ev[sel[0]] = 1'b1;

      rst    = r;
      ev_req = ev;
      for (int i = 0; i < 2; i++) begin
        if (m_wait[i][c] != 2'd0) tx_done[i] = m_done[i][c];
        else tx_done[i] = ($urandom_range(0, 4) == 0);
      end

      #3;
      if (c > 0) begin
        for (int i = 0; i < 2; i++) begin
          exp_d = m_en[i][c] ? m_byte[i][c] : m_last[i];
          chk($sformatf("tx_en[%0d]@%0d", i, c), 32'(tx_en[i]), 32'(m_en[i][c]));
          chk($sformatf("tx_data[%0d]@%0d", i, c), 32'(tx_data[i]), 32'(exp_d));
          chk($sformatf("cmd_sent[%0d]@%0d", i, c), 32'(cmd_sent[i]), 32'(m_sent[i][c]));
          chk($sformatf("busy[%0d]@%0d", i, c), 32'(busy[i]),
              32'((c >= m_blo[i] && c <= m_bhi[i]) ? 1 : 0));
          chk($sformatf("pending[%0d]@%0d", i, c), 32'(pending[i]), 32'(m_pend[i]));
          m_last[i] = exp_d;
        end
      end

      // Advance the model past this clock edge.
      for (int i = 0; i < 2; i++) begin
        if (r) begin
          m_pend[i] = 10'd0;
          m_last[i] = 8'h00;
          m_free[i] = c + 1;
          m_blo[i]  = 1;
          m_bhi[i]  = 0;
          for (int x = c + 1; x < MAXC && x < c + 64; x++) begin
            m_en[i][x]   = 1'b0;
            m_sent[i][x] = 1'b0;
            m_wait[i][x] = 2'd0;
            m_done[i][x] = 1'b0;
          end
        end else begin
          m_pend[i] = (m_pend[i] & ~clr[i]) | ev;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_tx_encoder.md
CMD_TX_ENCODER -- requirements
Module: cmd_tx_encoder

Interface
REQ-001 Parameter GAP_CYCLES, default 16, idle clock cycles inserted after each complete command before the next may start.
REQ-002 Parameter CMD_W, default 16, command width in bits: two ASCII bytes, first character in bits [15:8].
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ev_req  input  10  one-cycle event request pulses; bit k selects command k.
REQ-006 tx_done  input  1  one-cycle pulse from the UART transmitter: the current byte is fully sent.
REQ-007 tx_data  output  8  byte presented to the UART transmitter.
REQ-008 tx_en  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 cmd_sent  output  1  one-cycle pulse when both bytes of a command have completed.
REQ-011 pending  output  10  registered queue of requested commands not yet started.

Function
REQ-012 Command table, index 0..9: "G1","G0","H1","H0","I1","I0","J1","J0","O1","O0".
REQ-013 ev_req[k] high sets pending[k] on the next edge; repeated requests for an already-pending bit merge into one.
REQ-014 FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, GAP.
REQ-015 IDLE with pending nonzero: latch the lowest set index, clear that pending bit, go to SEND_HI.
REQ-016 If a set and a clear of the same pending bit occur in one cycle, the set wins.
REQ-017 SEND_HI: tx_en=1 for exactly one cycle, tx_data=first char; go to WAIT_HI.
REQ-018 WAIT_HI: hold tx_data; on tx_done go to SEND_LO.
REQ-019 SEND_LO: tx_en=1 for exactly one cycle, tx_data=second char; go to WAIT_LO.
REQ-020 WAIT_LO: on tx_done, pulse cmd_sent for one cycle and go to GAP.
REQ-021 GAP: count GAP_CYCLES cycles, then go to IDLE; GAP_CYCLES=0 returns to IDLE on the next cycle.
REQ-022 tx_done outside WAIT_HI and WAIT_LO is ignored.
REQ-023 There is no timeout; the FSM waits indefinitely for tx_done.
REQ-024 tx_data holds its last value whenever tx_en is low.
REQ-025 Latency: ev_req edge N -> pending at N+1 -> tx_en at N+3, provided the FSM is in IDLE.
REQ-026 Requests arriving during a command are queued, never dropped; they are served in index order after GAP.
REQ-027 Gap counter width is $clog2(GAP_CYCLES+1) bits; it never wraps.

Reset
REQ-028 rst forces: state IDLE, pending=0, tx_en=0, tx_data=8'h00, busy=0, cmd_sent=0, gap counter=0.
REQ-029 rst asserted mid-command abandons the command with no further tx_en and no cmd_sent.
REQ-030 rst has priority over ev_req in the same cycle.

Structure
REQ-031 Package cmd_pkg holds: the 10-entry command table, the index constants (CMD_G1..CMD_O0), and the FSM state encoding.
REQ-032 Sub-module cmd_arb: combinational lowest-index priority encoder over pending, with outputs idx[3:0] and valid.
REQ-033 All outputs are registered.

Verification
REQ-034 ev_req=10'b1 at one cycle, tx_done returned 4 cycles after each tx_en -> tx_en twice with tx_data 0x47 then 0x31, then one cmd_sent pulse.
REQ-035 ev_req=10'b1000000001 in a single cycle -> "G1" (0x47,0x31), then at least 16 cycles gap, then "O0" (0x4F,0x30).
REQ-036 ev_req[2] pulsed 3 times while busy on index 0 -> "H1" (0x48,0x31) sent exactly once after the gap.
REQ-037 rst asserted while in WAIT_LO -> next cycle all outputs are 0 and no cmd_sent; later "I1" request sends 0x49,0x31 normally.
REQ-038 Spurious tx_done in IDLE and GAP -> no state change; with GAP_CYCLES=0, back-to-back "J1","J0" -> 0x4A,0x31,0x4A,0x30.
REQ-039 ev_req[4] re-requested in the cycle it is selected -> pending[4]=1 afterwards and "I1" is sent twice.
